// File: rtl/modn_counter_pkg.sv
// Shared definitions for the cascaded modulo-N counter: digit width helper
// and the direction/mode encodings of the up and sat inputs.
package modn_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic int unsigned digit_width(input int unsigned radix);
        return $clog2(radix);
    endfunction

endpackage

// File: rtl/modn_digit.sv
// One modulo-RADIX digit: clamped parallel load, single up/down step, and
// registered limit flags that feed the carry/borrow chain in the parent.
module modn_digit
    import modn_counter_pkg::*;
#(
    parameter int unsigned RADIX = 10,
    parameter int unsigned W     = digit_width(RADIX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         at_max,
    output logic         at_min
);

    localparam logic [W-1:0] MAX_VAL = W'(RADIX - 1);

    logic [W-1:0] value_d, value_q;
    logic         at_max_d, at_max_q;
    logic         at_min_d, at_min_q;

    // Next digit value; the limit flags are precomputed from it so they are flops.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            if (up == DIR_UP) begin
                value_d = at_max_q ? '0 : value_q + W'(1);
            end else begin
                value_d = at_min_q ? MAX_VAL : value_q - W'(1);
            end
        end
        at_max_d = (value_d == MAX_VAL);
        at_min_d = (value_d == '0);
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= '0;
            at_max_q <= (MAX_VAL == '0);
            at_min_q <= 1'b1;
        end else begin
            value_q  <= value_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign value  = value_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;

endmodule

// File: rtl/modn_cascade_counter.sv
// Cascaded DIGITS x modulo-RADIX up/down counter with wrap or saturate mode,
// terminal-count pulse and sticky overflow; all state updates on falling clk.
module modn_cascade_counter
    import modn_counter_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned RADIX  = 10,
    localparam int unsigned W     = digit_width(RADIX)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up,
    input  logic                sat,
    input  logic                load,
    input  logic [DIGITS*W-1:0] load_val,
    input  logic                clr_ovf,
    output logic [DIGITS*W-1:0] q,
    output logic                tc,
    output logic                ovf
);

    logic [DIGITS-1:0] at_max, at_min;
    logic [DIGITS-1:0] carry_c, step_c;
    logic              run_c, limit_c, move_c;
    logic              tc_d, tc_q;
    logic              ovf_d, ovf_q;

    // Carry/borrow chain: digit k steps when every lower digit sits at its limit.
    always_comb begin
        carry_c = '0;
        step_c  = '0;
        run_c   = 1'b1;
        move_c  = en & ~load;
        for (int k = 0; k < int'(DIGITS); k++) begin
            carry_c[k] = run_c;
            run_c      = run_c & ((up == DIR_UP) ? at_max[k] : at_min[k]);
        end
        limit_c = run_c;
        if (move_c && !(limit_c && (sat == MODE_SAT))) begin
            step_c = carry_c;
        end
        tc_d  = move_c & limit_c & (sat == MODE_WRAP);
        ovf_d = (move_c & limit_c) | (ovf_q & ~clr_ovf);
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        modn_digit #(
            .RADIX (RADIX),
            .W     (W)
        ) u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .step     (step_c[g]),
            .up       (up),
            .load     (load),
            .load_val (load_val[g*W +: W]),
            .value    (q[g*W +: W]),
            .at_max   (at_max[g]),
            .at_min   (at_min[g])
        );
    end

    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule
